// File: rtl/fc_link_tx.sv
// fc_link_tx -- Fibre Channel link transmit word mux.
//
// Chooses the 32-bit transmission word sent to the PHY each cycle: primitive
// sequences while the link is not up, IDLE fill between frames, frame words
// from the upstream source, and an EOFa when a frame is cut off by a link
// state change.
//
// The port state code on 'state' is shared with the receive state machine:
//   0 LF1, 1 LF2, 2 OL1, 3 OL2, 4 OL3, 5 LR1, 6 LR2, 7 LR3, 8 AC
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   state[3:0], is_active    FC_Port state and "active, hold-off done"
//   in_data/in_datak         frame word and its K flags
//   in_sop/in_eop/in_valid   framing and word-present strobes
//   in_ready                 word accepted when in_valid && in_ready
//   data/datak               registered transmit word (K28.5 in byte 3)
//   abort_count              saturating count of aborted frames
//   underrun_count           saturating count of IDLEs inserted mid-frame
module fc_link_tx #(
    parameter int          MIN_IDLES = 6,
    parameter logic [31:0] EOFA_WORD = 32'hBC95F5F5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  state,
    input  logic        is_active,
    input  logic [31:0] in_data,
    input  logic [3:0]  in_datak,
    input  logic        in_sop,
    input  logic        in_eop,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] data,
    output logic [3:0]  datak,
    output logic [15:0] abort_count,
    output logic [15:0] underrun_count
);

    localparam logic [3:0] ST_LF1 = 4'd0, ST_LF2 = 4'd1, ST_OL1 = 4'd2,
                           ST_OL2 = 4'd3, ST_OL3 = 4'd4, ST_LR1 = 4'd5,
                           ST_LR2 = 4'd6, ST_LR3 = 4'd7, ST_AC  = 4'd8;

    localparam logic [31:0] W_IDLE = 32'hBC95B5B5;
    localparam logic [31:0] W_NOS  = 32'hBC55BF45;
    localparam logic [31:0] W_OLS  = 32'hBC358A55;
    localparam logic [31:0] W_LR   = 32'hBC49BF49;
    localparam logic [31:0] W_LRR  = 32'hBC35BF49;
    localparam logic [3:0]  K_OS   = 4'b1000;

    localparam int          GW       = $clog2(MIN_IDLES + 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(MIN_IDLES);

    typedef enum logic [1:0] {M_PRIM, M_GAP, M_FRAME, M_ABORT} mode_t;

    mode_t       mode, mode_n;
    logic [GW-1:0] gap, gap_n;
    logic        flush, flush_n;
    logic [31:0] data_n;
    logic [3:0]  datak_n;
    logic        abort_inc, under_inc;
    logic        ac, accept;

    function automatic logic [31:0] prim_word(input logic [3:0] s);
        case (s)
            ST_LF1, ST_OL1: prim_word = W_OLS;
            ST_LF2, ST_OL3: prim_word = W_NOS;
            ST_OL2, ST_LR1: prim_word = W_LR;
            ST_LR2:         prim_word = W_LRR;
            ST_LR3, ST_AC:  prim_word = W_IDLE;
            default:        prim_word = W_NOS;
        endcase
    endfunction

    assign ac     = (state == ST_AC);
    assign accept = in_valid && in_ready;

    // While flushing the remains of an aborted frame the source is drained
    // at full rate regardless of what the transmit side is doing.
    always_comb begin
        in_ready = flush;
        if (mode == M_GAP && ac && is_active && gap == '0)
            in_ready = 1'b1;
        if (mode == M_FRAME && ac && is_active)
            in_ready = 1'b1;
    end

    always_comb begin
        mode_n    = mode;
        gap_n     = gap;
        flush_n   = flush;
        data_n    = W_IDLE;
        datak_n   = K_OS;
        abort_inc = 1'b0;
        under_inc = 1'b0;

        if (flush && accept && in_eop)
            flush_n = 1'b0;

        unique case (mode)
            M_PRIM: begin
                data_n = prim_word(state);
                if (ac) begin
                    mode_n = M_GAP;
                    gap_n  = GAP_LOAD;
                end
            end
            M_GAP: begin
                if (!ac) begin
                    mode_n = M_PRIM;
                    gap_n  = GAP_LOAD;
                end else begin
                    if (gap != '0)
                        gap_n = gap - GW'(1);
                    // Non-SOP words here are stray tails: dropped, IDLE sent.
                    if (accept && !flush && in_sop) begin
                        data_n  = in_data;
                        datak_n = in_datak;
                        if (in_eop)
                            gap_n = GAP_LOAD;
                        else
                            mode_n = M_FRAME;
                    end
                end
            end
            M_FRAME: begin
                if (!ac || !is_active) begin
                    data_n    = EOFA_WORD;
                    mode_n    = M_ABORT;
                    abort_inc = 1'b1;
                    flush_n   = 1'b1;
                end else if (in_valid) begin
                    data_n  = in_data;
                    datak_n = in_datak;
                    if (in_eop) begin
                        mode_n = M_GAP;
                        gap_n  = GAP_LOAD;
                    end
                end else begin
                    under_inc = 1'b1;
                end
            end
            M_ABORT: begin
                // EOFa is on the wire this cycle; resume primitives.
                data_n = prim_word(state);
                mode_n = M_PRIM;
            end
            default: mode_n = M_PRIM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode           <= M_PRIM;
            gap            <= GAP_LOAD;
            flush          <= 1'b0;
            data           <= W_NOS;
            datak          <= K_OS;
            abort_count    <= 16'd0;
            underrun_count <= 16'd0;
        end else begin
            mode  <= mode_n;
            gap   <= gap_n;
            flush <= flush_n;
            data  <= data_n;
            datak <= datak_n;
            if (abort_inc && !(&abort_count))
                abort_count <= abort_count + 16'd1;
            if (under_inc && !(&underrun_count))
                underrun_count <= underrun_count + 16'd1;
        end
    end

endmodule

// File: doc/fc_link_tx.md
FC_LINK_TX -- requirements
Module: fc_link_tx

Interface
REQ-001 Parameter MIN_IDLES, 6: minimum IDLE words between consecutive frames.
REQ-002 Parameter EOFA_WORD, 32'hBC95F5F5: ordered set emitted when a frame is aborted.
REQ-003 clk  in  1  clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 state  in  fc::state_t  current FC_Port state from the receive state machine.
REQ-006 is_active  in  1  port active and post-entry IDLE hold-off complete.
REQ-007 in_data  in  32  frame word; in_datak  in  4  its K flags.
REQ-008 in_sop, in_eop  in  1 each  first/last word of frame; in_valid  in  1  word present.
REQ-009 in_ready  out  1  word accepted when in_valid && in_ready.
REQ-010 data  out  32, datak  out  4  transmit word to PHY, K28.5 in byte 3.
REQ-011 abort_count, underrun_count  out  16 each  saturating event counters.

Function
REQ-012 Encodings (datak 4'b1000): IDLE BC95B5B5, NOS BC55BF45, OLS BC358A55, LR BC49BF49, LRR BC35BF49.
REQ-013 data/datak registered; accepted word appears exactly 1 cycle after acceptance.
REQ-014 Modes: PRIM, GAP, FRAME, ABORT, plus flush flag.
REQ-015 PRIM emits per state: LF1->OLS, LF2->NOS, OL1->OLS, OL2->LR, OL3->NOS, LR1->LR, LR2->LRR, LR3->IDLE, AC->IDLE.
REQ-016 PRIM -> GAP when state==AC; gap counter loads MIN_IDLES.
REQ-017 GAP emits IDLE each cycle, decrementing gap counter to floor 0; any state!=AC returns to PRIM and reloads counter.
REQ-018 in_ready in GAP = state==AC && is_active && gap==0.
REQ-019 GAP acceptance with in_sop=1 -> FRAME, word forwarded; without in_sop -> word discarded, IDLE emitted, stays GAP.
REQ-020 FRAME: in_ready = state==AC && is_active; accepted words forwarded unmodified; in_sop inside FRAME ignored.
REQ-021 FRAME, in_valid=0 while ready -> IDLE emitted, underrun_count +1, stay FRAME.
REQ-022 FRAME, accepted in_eop -> GAP, counter reloads MIN_IDLES on the following cycle.
REQ-023 FRAME, state!=AC or is_active=0 -> ABORT: emit EOFA_WORD one cycle, abort_count +1, set flush, then PRIM.
REQ-024 Flush: in_ready=1 regardless of mode; words discarded until an in_eop word is accepted, then flag clears; aborted frame never resumes.
REQ-025 Single-word frame (in_sop && in_eop) -> forwarded, directly to GAP.
REQ-026 Counters saturate at 16'hFFFF; no wrap.
REQ-027 state changes only affect output from the next cycle (one-cycle registered latency).

Reset
REQ-028 On reset: mode PRIM, data=NOS word, datak=4'b1000, in_ready=0, gap=MIN_IDLES, flush=0, both counters 0.
REQ-029 Reset mid-frame: frame dropped silently, no EOFa, abort_count stays 0.

Verification
REQ-030 state=LR2 -> data=BC35BF49 every cycle; state->LR3 -> BC95B5B5 next cycle.
REQ-031 state=AC, is_active=1 from reset release -> in_ready first high after 6 IDLE cycles in GAP.
REQ-032 3-word frame sop..eop continuous -> 3 words out at latency 1, then >=6 IDLEs before next sop accepted.
REQ-033 in_valid low 2 cycles mid-frame -> 2 IDLEs inserted, underrun_count=2, frame completes.
REQ-034 state->OL2 mid-frame -> one EOFA_WORD, abort_count=1, then LR (BC49BF49); remaining frame words discarded through eop.
REQ-035 abort_count preset near 16'hFFFF by 2 aborts beyond saturation -> holds 16'hFFFF.
